// File: rtl/matrix_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_op_scheduler - round-robin sequencer for the shared 4x4 subtractor   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module matrix_op_scheduler #(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_a0,
  input  logic [127:0] req_b0,
  input  logic [127:0] req_a1,
  input  logic [127:0] req_b1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [255:0] rsp_c,
  output logic         rsp_err,
  output logic         eng_start,
  output logic [127:0] eng_a,
  output logic [127:0] eng_b,
  input  logic [255:0] eng_c,
  input  logic         eng_done,
  output logic         busy,
  output logic [7:0]   err_count
);

  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] START_LAST   = SW'(START_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic            owner;
  logic            last_grant;
  logic [SW-1:0]   start_cnt;
  logic [TW-1:0]   wait_cnt;
  logic [127:0]    op_a;
  logic [127:0]    op_b;
  logic            winner;
  logic            accept;

  always_comb begin
    winner    = req_valid[1];
    if (&req_valid) winner = ~last_grant;
    req_ready = 2'b00;
    if (state == IDLE && |req_valid) req_ready = winner ? 2'b10 : 2'b01;
  end

  assign accept = |(req_valid & req_ready);
  assign eng_a  = op_a;
  assign eng_b  = op_b;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      start_cnt  <= '0;
      wait_cnt   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 2'b00;
      rsp_c      <= '0;
      rsp_err    <= 1'b0;
      eng_start  <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= winner ? req_a1 : req_a0;
            op_b       <= winner ? req_b1 : req_b0;
            owner      <= winner;
            last_grant <= winner;
            start_cnt  <= '0;
            eng_start  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (start_cnt == START_LAST) begin
            eng_start <= 1'b0;
            wait_cnt  <= '0;
            state     <= WAIT;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        WAIT: begin
          // Error is declared only after TIMEOUT_CYCLES full WAIT cycles without done.
          if (eng_done) begin
            rsp_c     <= eng_c;
            rsp_err   <= 1'b0;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            rsp_c     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_op_scheduler.sv
`default_nettype none
// tb_matrix_op_scheduler - randomized requesters and engine, checked against a
// transaction-level model of arbitration, latency, results and error counting.
module tb_matrix_op_scheduler;

  localparam int S = 2;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] ra [2];
  logic [127:0] rb [2];
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [255:0] rsp_c;
  logic         rsp_err;
  logic         eng_start;
  logic [127:0] eng_a;
  logic [127:0] eng_b;
  logic [255:0] eng_c;
  logic         eng_done;
  logic         busy;
  logic [7:0]   err_count;

  always #5 clk = ~clk;

  matrix_op_scheduler #(.START_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(ra[0]), .req_b0(rb[0]), .req_a1(ra[1]), .req_b1(rb[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c),
    .eng_done(eng_done), .busy(busy), .err_count(err_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mat_sub(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c[16*i +: 16] = {8'h00, a[8*i +: 8]} - {8'h00, b[8*i +: 8]};
    return c;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Engine model: result computed on start; done rises delay+1 cycles after start falls
  // (never if delay < 0). eng_stale forces done high regardless.
  int           eng_delay = 0;
  bit           eng_stale = 1'b0;
  logic         done_r = 1'b0;
  int           cd = 0;
  bit           armed = 1'b0;
  logic [255:0] c_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
      armed  <= 1'b0;
      cd     <= 0;
      c_r    <= '0;
    end else if (eng_start) begin
      c_r    <= mat_sub(eng_a, eng_b);
      done_r <= 1'b0;
      armed  <= 1'b1;
      cd     <= eng_delay;
    end else if (armed && cd >= 0) begin
      if (cd == 0) begin
        done_r <= 1'b1;
        armed  <= 1'b0;
      end else begin
        cd <= cd - 1;
      end
    end
  end

  assign eng_done = done_r | eng_stale;
  assign eng_c    = c_r;

  // Reference model state
  bit [1:0] pending = 2'b00;
  int       model_last = 1;
  int       model_err = 0;

  task automatic check_reset_state();
    check_eq("rst_ctrl", {req_ready, rsp_valid, rsp_err, eng_start, busy, err_count}, '0);
    check_eq("rst_rsp_c", rsp_c, '0);
    check_eq("rst_eng_ab", {eng_a, eng_b}, '0);
  endtask

  // Entered just after a negedge with the DUT in IDLE; returns just after the
  // negedge of the IDLE cycle that follows the response handshake.
  task automatic transact(input logic [1:0] mask, input int delay, input bit stale, input int bp);
    int           w;
    int           k;
    int           starts;
    int           exp_lat;
    bit           exp_err;
    bit           ready_leak;
    logic [255:0] exp_c;
    logic [1:0]   oh;
    for (int r = 0; r < 2; r++) begin
      if (mask[r] && !pending[r]) begin
        ra[r] = rand128();
        rb[r] = rand128();
        pending[r] = 1'b1;
      end
    end
    req_valid = mask;
    eng_delay = delay;
    eng_stale = stale;
    rsp_ready = (bp == 0) ? 2'b11 : 2'b00;
    #1;
    w  = (mask == 2'b11) ? (model_last == 1 ? 0 : 1) : (mask[1] ? 1 : 0);
    oh = (w == 1) ? 2'b10 : 2'b01;
    check_eq("grant", req_ready, oh);
    check_eq("busy_idle", busy, 1'b0);
    exp_c   = mat_sub(ra[w], rb[w]);
    exp_err = (delay < 0) && !stale;
    exp_lat = stale ? S + 2 : (exp_err ? S + T + 2 : S + 3 + delay);
    if (exp_err) exp_c = '0;
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    pending[w]   = 1'b0;
    model_last   = w;
    if (exp_err && model_err < 255) model_err++;
    k = 0; starts = 0; ready_leak = 1'b0;
    while (k < S + T + 10) begin
      @(negedge clk);
      k++;
      if (eng_start) starts++;
      if (req_ready != 2'b00) ready_leak = 1'b1;
      if (rsp_valid != 2'b00) break;
    end
    check_eq("latency", k, exp_lat);
    check_eq("start_len", starts, S);
    check_eq("rsp_owner", rsp_valid, oh);
    check_eq("rsp_c", rsp_c, exp_c);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("err_count", err_count, model_err);
    check_eq("no_accept_busy", ready_leak, 1'b0);
    if (bp > 0) begin
      rsp_ready = ~oh;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        check_eq("bp_valid", rsp_valid, oh);
        check_eq("bp_c", rsp_c, exp_c);
        check_eq("bp_ready", req_ready, 2'b00);
      end
      rsp_ready = oh;
    end
    @(negedge clk);
    check_eq("idle_after", {rsp_valid, busy, eng_start}, '0);
    rsp_ready = 2'b00;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mask;
    int dly;
    bit no_rsp;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int r = 0; r < 2; r++) begin
      ra[r] = '0;
      rb[r] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    // Tie arbitration from reset: 0,1,0,1
    repeat (4) transact(2'b11, $urandom_range(0, 6), 1'b0, 0);

    // Directed: a=200, b=55 everywhere; done three cycles after start falls
    ra[0] = {16{8'd200}};
    rb[0] = {16{8'd55}};
    pending[0] = 1'b1;
    transact(2'b01 | pending, 2, 1'b0, 0);

    // Stale done held high through IDLE/ISSUE
    transact((($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01) | pending, 0, 1'b1, 0);

    // Timeout
    transact(2'b01 | pending, -1, 1'b0, 0);

    // Backpressure with the other requester waiting, then its grant
    transact(2'b11, 3, 1'b0, 10);
    transact(2'b11, 1, 1'b0, 0);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      mask = $urandom_range(1, 3);
      dly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
      transact(2'(mask) | pending, dly, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Reset during WAIT of an operation owned by requester 0
    if (!pending[0]) begin
      ra[0] = rand128();
      rb[0] = rand128();
    end
    req_valid = 2'b01;
    eng_delay = -1;
    eng_stale = 1'b0;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    req_valid = 2'b00;
    pending   = 2'b00;
    repeat (S + 3) @(negedge clk);
    check_eq("busy_wait", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    model_last = 1;
    model_err  = 0;
    no_rsp = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) no_rsp = 1'b0;
    end
    check_eq("no_rsp_after_rst", no_rsp, 1'b1);
    transact(2'b11, 1, 1'b0, 0);
    transact(2'b11, 2, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
